// File: rtl/alu_pkg.sv
// Shared ALU control codes and output-buffer state encoding.
// The ALU control decoder and the execution side both use these constants.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_e;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU datapath selected by the 4-bit control code.
// Shared by the single-cycle datapath and the multi-cycle execution unit.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       code,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  logic [WIDTH-1:0] diff;
  logic             slt;

  assign diff = a - b;
  // Differing signs cannot overflow the compare: the negative operand is smaller.
  assign slt  = (a[WIDTH-1] ^ b[WIDTH-1]) ? a[WIDTH-1] : diff[WIDTH-1];

  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (code)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_SUB: result = diff;
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, slt};
      ALU_NOR: result = ~(a | b);
      default: illegal = 1'b1;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: accepts an operation, computes it with alu_core and
// queues {result, zero, illegal} in a 2-entry FIFO toward writeback.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal,
  output logic [1:0]       dbg_state
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             illegal;
  } entry_t;

  entry_t     core_out;
  entry_t     mem [2];
  logic       head;
  logic       tail;
  buf_state_e state;
  logic       in_xfer;
  logic       out_xfer;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .code    (alu_ctl),
    .a       (op_a),
    .b       (op_b),
    .result  (core_out.result),
    .zero    (core_out.zero),
    .illegal (core_out.illegal)
  );

  // Handshake: a transfer happens on a rising edge where valid && ready on
  // that side; ready never looks at the peer's valid, and both ready/valid
  // come from the state register only.
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= EMPTY;
      head  <= 1'b0;
      tail  <= 1'b0;
    end else begin
      if (in_xfer)  tail <= ~tail;
      if (out_xfer) head <= ~head;
      case ({in_xfer, out_xfer})
        2'b10:   state <= (state == EMPTY) ? ONE : FULL;
        2'b01:   state <= (state == FULL) ? ONE : EMPTY;
        default: state <= state;
      endcase
    end
  end

  // Payload storage needs no reset; the state register decides what is live.
  always_ff @(posedge clk) begin
    if (rst_n && in_xfer) mem[tail] <= core_out;
  end

  assign result    = out_valid ? mem[head].result  : '0;
  assign zero      = out_valid ? mem[head].zero    : 1'b0;
  assign illegal   = out_valid ? mem[head].illegal : 1'b0;
  assign dbg_state = state;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: vector table streamed at full rate,
// plus hand-written reset, backpressure and mid-operation reset sequences.
module tb_alu_exec_unit;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   alu_ctl;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         illegal;
  logic [1:0]   dbg_state;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctl   (alu_ctl),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: entries packed as {illegal, zero, result}
  logic [W+1:0] exp_q[$];
  logic [W+1:0] cur_exp;
  int           n_checks = 0;
  int           n_fail   = 0;

  typedef struct {
    logic [3:0]   ctl;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         z;
    logic         ill;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [W+1:0] act, input logic [W+1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver: present an operation and remember what it should produce.
  task automatic drive(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] r, input logic z, input logic il);
    in_valid = 1'b1;
    alu_ctl  = c;
    op_a     = a;
    op_b     = b;
    cur_exp  = {il, z, r};
  endtask

  // One clock of traffic with scoreboard bookkeeping of both handshakes.
  task automatic step();
    logic         ix;
    logic         ox;
    logic [W+1:0] e;
    ix = in_valid && in_ready;
    ox = out_valid && out_ready;
    if (ox) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", {illegal, zero, result}, '1);
      end else begin
        e = exp_q.pop_front();
        check("sb_entry", {illegal, zero, result}, e);
      end
    end
    if (ix) exp_q.push_back(cur_exp);
    tick();
  endtask

  initial begin
    vecs[0]  = '{4'b0110, 32'd3,        32'd3,        32'd0,        1'b1, 1'b0};
    vecs[1]  = '{4'b0000, 32'hF0,       32'h3C,       32'h30,       1'b0, 1'b0};
    vecs[2]  = '{4'b1100, 32'd0,        32'd0,        32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[3]  = '{4'b0111, 32'h80000000, 32'd1,        32'd1,        1'b0, 1'b0};
    vecs[4]  = '{4'b0111, 32'd1,        32'h80000000, 32'd0,        1'b1, 1'b0};
    vecs[5]  = '{4'b0111, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'd0,        1'b1, 1'b0};
    vecs[6]  = '{4'b1111, 32'd9,        32'd4,        32'd0,        1'b1, 1'b1};
    vecs[7]  = '{4'b0010, 32'd9,        32'd4,        32'd13,       1'b0, 1'b0};
    vecs[8]  = '{4'b0001, 32'h0F00,     32'h00F0,     32'h0FF0,     1'b0, 1'b0};
    vecs[9]  = '{4'b0111, 32'hFFFFFFFF, 32'd0,        32'd1,        1'b0, 1'b0};
    vecs[10] = '{4'b0110, 32'd0,        32'd1,        32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[11] = '{4'b0011, 32'd5,        32'd7,        32'd0,        1'b1, 1'b1};

    // Reset with an operation offered: nothing accepted, outputs idle.
    rst_n     = 1'b0;
    out_ready = 1'b0;
    drive(4'b0010, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("reset_out_valid", out_valid, 0);
      check("reset_in_ready", in_ready, 1);
      check("reset_payload", {illegal, zero, result}, 0);
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    tick();
    check("post_reset_out_valid", out_valid, 0);

    // First operation: visible the cycle after acceptance.
    out_ready = 1'b1;
    drive(4'b0010, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    check("add_latency_valid", out_valid, 1);
    check("add_5_7", {illegal, zero, result}, {1'b0, 1'b0, 32'd12});
    step();
    check("drained_valid", out_valid, 0);
    check("drained_payload", {illegal, zero, result}, 0);

    // Table vectors streamed back to back at one per cycle.
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].ctl, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].z, vecs[i].ill);
      check($sformatf("stream_in_ready_%0d", i), in_ready, 1);
      step();
      check($sformatf("vec_%0d", i), {out_valid, illegal, zero, result},
            {1'b1, vecs[i].ill, vecs[i].z, vecs[i].res});
    end
    in_valid = 1'b0;
    step();
    check("stream_drained", out_valid, 0);

    // Backpressure: two accepted, third held until space frees.
    out_ready = 1'b0;
    drive(4'b0010, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0);
    step();
    drive(4'b0110, 32'd10, 32'd4, 32'd6, 1'b0, 1'b0);
    check("bp_second_ready", in_ready, 1);
    step();
    drive(4'b0001, 32'h5, 32'hA, 32'hF, 1'b0, 1'b0);
    check("bp_full_ready", in_ready, 0);
    check("bp_full_state", dbg_state, 2);
    step();
    step();
    check("bp_head_stable", {out_valid, result}, {1'b1, 32'd3});
    out_ready = 1'b1;
    check("bp_ready_indep_of_out_ready", in_ready, 0);
    step();
    check("bp_space_freed", {in_ready, result}, {1'b1, 32'd6});
    step();
    check("bp_third_accepted", {dbg_state, result}, {2'd1, 32'hF});
    in_valid = 1'b0;
    step();
    check("bp_drained", out_valid, 0);
    check("bp_queue_empty", exp_q.size(), 0);

    // Reset while FULL: old entries vanish, next op behaves normally.
    out_ready = 1'b0;
    drive(4'b0010, 32'd100, 32'd1, 32'd101, 1'b0, 1'b0);
    step();
    drive(4'b0010, 32'd200, 32'd1, 32'd201, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    check("mid_full_before_reset", in_ready, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    check("mid_reset_out_valid", out_valid, 0);
    check("mid_reset_in_ready", in_ready, 1);
    out_ready = 1'b1;
    step();
    check("mid_no_stale_entry", out_valid, 0);
    drive(4'b0010, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1, 1'b0);
    step();
    in_valid = 1'b0;
    check("wrap_add", {out_valid, illegal, zero, result}, {1'b1, 1'b0, 1'b1, 32'd0});
    step();
    check("final_drained", out_valid, 0);
    check("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
